sample_framer: RTL and testbench

- Sits between the 8-bit offset-corrected channel samples (ch1/ch2 after sign conversion) and a UART byte transmitter.
- Decimates the sample streams to a fixed rate and buffers sample pairs in a FIFO.
- Serialises each pair as a 5-byte frame over a valid/ready byte handshake, so the host can resynchronise and detect lost frames.

---
 rtl/sample_framer_if.sv | 16 +
 rtl/sample_framer.sv | 140 ++++++++++++++
 tb/tb_sample_framer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/sample_framer_if.sv
// sample_framer_if
// Byte stream handshake between the sample framer and a UART byte transmitter.
//   tx_data  : byte offered to the transmitter
//   tx_valid : tx_data holds a byte to be taken
//   tx_ready : transmitter takes the byte on the next clock edge
// master = byte source (framer), slave = byte sink (transmitter).
interface sample_framer_if #(
    parameter int DATA_SIZE = 8
);
    logic [DATA_SIZE-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/sample_framer.sv
// sample_framer
// Decimates the two channel sample streams, buffers captured pairs in a FIFO
// and sends each pair as a 5-byte frame: SYNC, seq, ch1, ch2, checksum.
//   i_clock, i_reset    : clock, asynchronous active-high reset
//   i_enable            : capture enable (ADC init done)
//   i_data_ch1/ch2      : channel samples, sampled only on the capture edge
//   tx (master)         : registered byte stream towards the transmitter
//   o_overflow          : sticky, a captured pair was dropped on a full FIFO
//   o_fifo_level        : pairs currently held in the FIFO
module sample_framer #(
    parameter int                   DATA_SIZE   = 8,
    parameter int                   DECIM_TICKS = 10000,
    parameter int                   FIFO_DEPTH  = 16,
    parameter logic [DATA_SIZE-1:0] SYNC_BYTE   = 8'hA5
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_enable,
    input  logic [DATA_SIZE-1:0]          i_data_ch1,
    input  logic [DATA_SIZE-1:0]          i_data_ch2,
    sample_framer_if.master               tx,
    output logic                          o_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

    localparam int CNT_W = $clog2(DECIM_TICKS);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DECIM_LAST = CNT_W'(DECIM_TICKS - 1);
    localparam logic [LVL_W-1:0] LEVEL_FULL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, SYNC, SEQ, CH1, CH2, CSUM} state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       decim_cnt;
    logic [PTR_W-1:0]       wr_ptr, rd_ptr;
    logic [LVL_W-1:0]       level;
    logic [2*DATA_SIZE-1:0] mem [FIFO_DEPTH];
    logic [DATA_SIZE-1:0]   hold_ch1, hold_ch2, seq_q;
    logic [DATA_SIZE-1:0]   data_d;
    logic                   valid_d;
    logic                   capture, pop, push;

    assign capture      = i_enable && (decim_cnt == DECIM_LAST);
    // The frame FSM only pops while idle, so a pop never races a frame in flight.
    assign pop          = (state_q == IDLE) && (level != '0);
    // A full FIFO still takes a pair when the head leaves on the same edge.
    assign push         = capture && ((level != LEVEL_FULL) || pop);
    assign o_fifo_level = level;

    // Decimation counter: held at zero while disabled so the first capture
    // lands DECIM_TICKS edges after enable rises.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            decim_cnt <= '0;
        end else if (!i_enable || capture) begin
            decim_cnt <= '0;
        end else begin
            decim_cnt <= decim_cnt + 1'b1;
        end
    end

    // Storage array carries no reset; validity is tracked by the pointers.
    always_ff @(posedge i_clock) begin
        if (push) begin
            mem[wr_ptr] <= {i_data_ch1, i_data_ch2};
        end
    end

    // Pointers, level, sticky overflow and the pair holding register.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            o_overflow <= 1'b0;
            hold_ch1   <= '0;
            hold_ch2   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr               <= rd_ptr + 1'b1;
                {hold_ch1, hold_ch2} <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (capture && !push) begin
                o_overflow <= 1'b1;
            end
        end
    end

    // Frame state register, sequence counter and registered byte outputs.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= IDLE;
            seq_q       <= '0;
            tx.tx_data  <= '0;
            tx.tx_valid <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx.tx_data  <= data_d;
            tx.tx_valid <= valid_d;
            if (state_q == CSUM && tx.tx_ready) begin
                seq_q <= seq_q + 1'b1;
            end
        end
    end

    // Next state, then the byte the next state presents. Outputs are decoded
    // from state_d so they can be registered without a ready-to-output path.
    always_comb begin
        state_d = state_q;
        data_d  = '0;
        valid_d = 1'b0;
        case (state_q)
            IDLE:    if (level != '0) state_d = SYNC;
            SYNC:    if (tx.tx_ready) state_d = SEQ;
            SEQ:     if (tx.tx_ready) state_d = CH1;
            CH1:     if (tx.tx_ready) state_d = CH2;
            CH2:     if (tx.tx_ready) state_d = CSUM;
            CSUM:    if (tx.tx_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        case (state_d)
            SYNC:    begin data_d = SYNC_BYTE;                    valid_d = 1'b1; end
            SEQ:     begin data_d = seq_q;                        valid_d = 1'b1; end
            CH1:     begin data_d = hold_ch1;                     valid_d = 1'b1; end
            CH2:     begin data_d = hold_ch2;                     valid_d = 1'b1; end
            CSUM:    begin data_d = seq_q + hold_ch1 + hold_ch2;  valid_d = 1'b1; end
            default: begin data_d = '0;                           valid_d = 1'b0; end
        endcase
    end

endmodule

// File: tb/tb_sample_framer.sv
// tb_sample_framer
// Drives sample_framer (DECIM_TICKS=4, FIFO_DEPTH=16) with directed and
// randomized stimulus. A queue-based model of captures, the pair FIFO and the
// frame being sent predicts valid/data/level/overflow every cycle; literal
// frame contents pin the model to known answers.
module tb_sample_framer;

    localparam int DECIM = 4;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] ch1, ch2;
    logic [4:0] level;
    logic       overflow;

    sample_framer_if #(.DATA_SIZE(8)) tx_if ();

    sample_framer #(
        .DATA_SIZE(8), .DECIM_TICKS(DECIM), .FIFO_DEPTH(DEPTH), .SYNC_BYTE(8'hA5)
    ) dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_enable     (en),
        .i_data_ch1   (ch1),
        .i_data_ch2   (ch2),
        .tx           (tx_if.master),
        .o_overflow   (overflow),
        .o_fifo_level (level)
    );

    always #5 clk = ~clk;

    int assertions = 0;
    int failures   = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        assertions++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    // Inputs change 2 time units after a rising edge so every edge sees stable values.
    // ready_mode: 0 = low, 1 = high, 2 = toggle, other = high 3 of 4 cycles at random.
    task automatic applyStimulus(input logic e, input logic [7:0] a, input logic [7:0] b,
                                 input int ready_mode, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #2;
            en  = e;
            ch1 = a;
            ch2 = b;
            case (ready_mode)
                0:       tx_if.tx_ready = 1'b0;
                1:       tx_if.tx_ready = 1'b1;
                2:       tx_if.tx_ready = ~tx_if.tx_ready;
                default: tx_if.tx_ready = ($urandom_range(3) != 0);
            endcase
        end
    endtask

    // Behavioural model: pairs waiting, bytes of the frame currently offered.
    logic [15:0] m_q[$];
    logic [7:0]  m_frame[$];
    int          m_seq;
    bit          m_ovf;
    int          m_run;
    bit          m_pop, m_cap;
    logic [15:0] m_pair;
    int          m_sum;

    // Model update on each edge: accept a byte, or start the next frame when
    // idle; then apply a capture (after the pop, so a full queue can take it).
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_frame.delete();
            m_seq = 0;
            m_ovf = 1'b0;
            m_run = 0;
        end else begin
            m_pop = (m_frame.size() == 0) && (m_q.size() > 0);
            if (m_frame.size() > 0 && tx_if.tx_ready) begin
                void'(m_frame.pop_front());
                if (m_frame.size() == 0) m_seq = (m_seq + 1) % 256;
            end
            m_cap = en && ((m_run % DECIM) == DECIM - 1);
            m_run = en ? m_run + 1 : 0;
            if (m_pop) begin
                m_pair = m_q.pop_front();
                m_sum  = (m_seq + int'(m_pair[15:8]) + int'(m_pair[7:0])) % 256;
                m_frame.push_back(8'hA5);
                m_frame.push_back(8'(m_seq));
                m_frame.push_back(m_pair[15:8]);
                m_frame.push_back(m_pair[7:0]);
                m_frame.push_back(8'(m_sum));
            end
            if (m_cap) begin
                if (m_q.size() < DEPTH) m_q.push_back({ch1, ch2});
                else                    m_ovf = 1'b1;
            end
        end
    end

    // Log of bytes the transmitter actually took, with the edge number.
    logic [7:0] dut_log[$];
    int         log_edge[$];
    int         edge_cnt = 0;

    always @(posedge clk) begin
        edge_cnt++;
        if (!rst && tx_if.tx_valid && tx_if.tx_ready) begin
            dut_log.push_back(tx_if.tx_data);
            log_edge.push_back(edge_cnt);
        end
    end

    // Per-cycle comparison against the model, on the falling edge.
    bit cmp_on = 1'b0;

    always @(negedge clk) begin
        if (cmp_on) begin
            checkOutput("valid", int'(tx_if.tx_valid), int'(m_frame.size() > 0));
            if (m_frame.size() > 0) checkOutput("data", int'(tx_if.tx_data), int'(m_frame[0]));
            checkOutput("level", int'(level), m_q.size());
            checkOutput("overflow", int'(overflow), int'(m_ovf));
        end
    end

    logic [7:0] exp1 [5]  = '{8'hA5, 8'h00, 8'h12, 8'h34, 8'h46};
    logic [7:0] exp2 [10] = '{8'hA5, 8'h01, 8'hFF, 8'h02, 8'h02,
                              8'hA5, 8'h02, 8'hFF, 8'h02, 8'h03};
    logic [7:0] exp6 [5]  = '{8'hA5, 8'h00, 8'h21, 8'h43, 8'h64};
    int  seq_start;
    int  budget;
    bit  wrap_seen;
    bit  reached;

    initial begin
        en = 1'b0; ch1 = '0; ch2 = '0; tx_if.tx_ready = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("reset_valid", int'(tx_if.tx_valid), 0);
        checkOutput("reset_data", int'(tx_if.tx_data), 0);
        checkOutput("reset_level", int'(level), 0);
        checkOutput("reset_overflow", int'(overflow), 0);
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b0;
        cmp_on = 1'b1;

        $display("[TB] single frame");
        applyStimulus(1'b1, 8'h12, 8'h34, 1, 5);
        applyStimulus(1'b0, 8'h00, 8'h00, 1, 12);
        checkOutput("t1_len", dut_log.size(), 5);
        for (int i = 0; i < 5; i++) checkOutput($sformatf("t1_byte%0d", i), int'(dut_log[i]), int'(exp1[i]));
        checkOutput("t1_level", int'(level), 0);

        $display("[TB] back-to-back frames");
        dut_log.delete(); log_edge.delete();
        applyStimulus(1'b1, 8'hFF, 8'h02, 1, 9);
        applyStimulus(1'b0, 8'h00, 8'h00, 1, 16);
        checkOutput("t2_len", dut_log.size(), 10);
        for (int i = 0; i < 10; i++) checkOutput($sformatf("t2_byte%0d", i), int'(dut_log[i]), int'(exp2[i]));
        checkOutput("t2_gap", log_edge[5] - log_edge[4], 2);

        $display("[TB] toggling ready");
        for (int i = 0; i < 30; i++) applyStimulus(1'b1, 8'($urandom), 8'($urandom), 2, 1);
        applyStimulus(1'b0, 8'h00, 8'h00, 2, 80);
        checkOutput("t3_level", int'(level), 0);

        $display("[TB] stalled transmitter");
        for (int i = 0; i < 80; i++) applyStimulus(1'b1, 8'($urandom), 8'($urandom), 0, 1);
        checkOutput("t4_level_full", int'(level), DEPTH);
        checkOutput("t4_overflow", int'(overflow), 1);
        dut_log.delete();
        seq_start = m_seq;
        applyStimulus(1'b0, 8'h00, 8'h00, 1, 17 * 6 + 10);
        // Sixteen buffered pairs plus the one already latched when the stall began.
        checkOutput("t4_len", dut_log.size(), 85);
        for (int k = 0; k < 17; k++) begin
            checkOutput($sformatf("t4_sync%0d", k), int'(dut_log[5*k]), 8'hA5);
            checkOutput($sformatf("t4_seq%0d", k), int'(dut_log[5*k+1]), (seq_start + k) % 256);
        end
        checkOutput("t4_overflow_sticky", int'(overflow), 1);

        $display("[TB] sequence wrap");
        dut_log.delete();
        seq_start = m_seq;
        budget = 0;
        while (dut_log.size() < 260 * 5 && budget < 6000) begin
            applyStimulus(1'b1, 8'($urandom), 8'($urandom), 3, 1);
            budget++;
        end
        checkOutput("t5_budget", int'(budget < 6000), 1);
        applyStimulus(1'b0, 8'h00, 8'h00, 1, 150);
        wrap_seen = 1'b0;
        for (int k = 0; k + 1 < dut_log.size() / 5; k++) begin
            if (dut_log[5*k+1] == 8'hFF && dut_log[5*k+6] == 8'h00) wrap_seen = 1'b1;
        end
        for (int k = 0; k < 260; k++)
            checkOutput($sformatf("t5_seq%0d", k), int'(dut_log[5*k+1]), (seq_start + k) % 256);
        checkOutput("t5_wrap", int'(wrap_seen), 1);

        $display("[TB] asynchronous reset mid-frame");
        reached = 1'b0;
        for (int i = 0; i < 50 && !reached; i++) begin
            applyStimulus(1'b1, 8'($urandom), 8'($urandom), 1, 1);
            if (m_frame.size() == 3) reached = 1'b1;
        end
        checkOutput("t6_reach_ch1", int'(reached), 1);
        #1 rst = 1'b1;
        #1;
        checkOutput("t6_valid", int'(tx_if.tx_valid), 0);
        checkOutput("t6_data", int'(tx_if.tx_data), 0);
        checkOutput("t6_level", int'(level), 0);
        checkOutput("t6_overflow", int'(overflow), 0);
        en = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0;
        dut_log.delete();
        applyStimulus(1'b1, 8'h21, 8'h43, 1, 5);
        applyStimulus(1'b0, 8'h00, 8'h00, 1, 12);
        checkOutput("t6_len", dut_log.size(), 5);
        for (int i = 0; i < 5; i++) checkOutput($sformatf("t6_byte%0d", i), int'(dut_log[i]), int'(exp6[i]));
        checkOutput("t6_overflow_after", int'(overflow), 0);

        cmp_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
